// File: rtl/ray_box_scan.sv
// Nearest-hit ray vs. axis-aligned box scan: a 3-stage slab pipe and a compare stage run over the box table.
// Define RAY_BOX_SCAN_ANY_HIT_EN to stop at the first (lowest-index) hit instead of finding the nearest.
module ray_box_scan #(
  parameter int W         = 24,
  parameter int FRAC      = 12,
  parameter int NUM_BOXES = 8,
  localparam int IDX_W    = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic             box_wr_en,
  input  logic [IDX_W-1:0] box_wr_idx,
  input  logic [3*W-1:0]   box_wr_min,
  input  logic [3*W-1:0]   box_wr_max,
  input  logic             ray_valid,
  output logic             ray_ready,
  input  logic [3*W-1:0]   ray_orig,
  input  logic [3*W-1:0]   ray_inv_dir,
  input  logic [W-1:0]     ray_t_max,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             result_hit,
  output logic [IDX_W-1:0] result_idx,
  output logic [W-1:0]     result_t,
  output logic [1:0]       scan_state
);

  // Handshakes: a transfer happens on the rising edge where valid && ready are both 1;
  // result_* are held stable while result_valid is high and not yet accepted.
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_BOXES - 1);

  state_t state, state_nx;
  logic [IDX_W-1:0] cnt;
  logic [3*W-1:0] tab_min [NUM_BOXES];
  logic [3*W-1:0] tab_max [NUM_BOXES];
  logic [3*W-1:0] orig_r, inv_r;
  logic signed [W-1:0] tmax_r;

  logic s1_valid, s2_valid, s3_valid;
  logic [IDX_W-1:0] s1_idx, s2_idx, s3_idx;
  logic signed [W:0]   s1_dlo [3];
  logic signed [W:0]   s1_dhi [3];
  logic signed [W-1:0] s2_tlo [3];
  logic signed [W-1:0] s2_thi [3];
  logic signed [W-1:0] s3_near, s3_far;
  logic signed [W-1:0] near_c, far_c, lo_v, hi_v, tc;
  logic hit_c, take, abort;

  logic best_valid;
  logic [IDX_W-1:0] best_idx;
  logic signed [W-1:0] best_t;

  function automatic logic signed [W:0] sx(input logic [W-1:0] v);
    return {v[W-1], v};
  endfunction

  // (d * inv) >>> FRAC, clamped to the W-bit signed range.
  function automatic logic signed [W-1:0] scale(input logic signed [W:0] d,
                                                input logic signed [W-1:0] inv);
    logic signed [2*W:0] p;
    p = d * inv;
    p = p >>> FRAC;
    if (p[2*W:W-1] == '0 || p[2*W:W-1] == '1) return $signed(p[W-1:0]);
    else if (p[2*W]) return {1'b1, {(W-1){1'b0}}};
    else return {1'b0, {(W-1){1'b1}}};
  endfunction

  always_comb begin
    near_c = '0;
    far_c  = '0;
    lo_v   = '0;
    hi_v   = '0;
    for (int a = 0; a < 3; a++) begin
      lo_v = (s2_tlo[a] < s2_thi[a]) ? s2_tlo[a] : s2_thi[a];
      hi_v = (s2_tlo[a] < s2_thi[a]) ? s2_thi[a] : s2_tlo[a];
      if (a == 0 || lo_v > near_c) near_c = lo_v;
      if (a == 0 || hi_v < far_c) far_c = hi_v;
    end
  end

  assign hit_c = (s3_near <= s3_far) && !s3_far[W-1] && (s3_near <= tmax_r);
  assign tc    = s3_near[W-1] ? '0 : s3_near;
  // Strict less-than keeps the lower index on equal distances.
  assign take  = s3_valid && hit_c && (!best_valid || tc < best_t);

`ifdef RAY_BOX_SCAN_ANY_HIT_EN
  assign abort = take;
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (ray_valid) state_nx = ISSUE;
      ISSUE: if (abort) state_nx = DONE;
             else if (cnt == LAST) state_nx = DRAIN;
      DRAIN: if (abort || (s3_valid && s3_idx == LAST)) state_nx = DONE;
      DONE:  if (result_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      s3_valid   <= 1'b0;
      best_valid <= 1'b0;
      best_idx   <= '0;
      best_t     <= '0;
      orig_r     <= '0;
      inv_r      <= '0;
      tmax_r     <= '0;
      for (int i = 0; i < NUM_BOXES; i++) begin
        tab_min[i] <= '0;
        tab_max[i] <= '0;
      end
    end else begin
      state    <= state_nx;
      s1_valid <= (state == ISSUE) && !abort;
      s2_valid <= s1_valid && !abort;
      s3_valid <= s2_valid && !abort;
      if (state == IDLE) begin
        cnt <= '0;
        if (box_wr_en && (int'(box_wr_idx) < NUM_BOXES)) begin
          tab_min[box_wr_idx] <= box_wr_min;
          tab_max[box_wr_idx] <= box_wr_max;
        end
        if (ray_valid) begin
          orig_r     <= ray_orig;
          inv_r      <= ray_inv_dir;
          tmax_r     <= ray_t_max;
          best_valid <= 1'b0;
          best_idx   <= '0;
          best_t     <= '0;
        end
      end else begin
        if (state == ISSUE) cnt <= cnt + 1'b1;
        if (take) begin
          best_valid <= 1'b1;
          best_idx   <= s3_idx;
          best_t     <= tc;
        end
      end
    end
  end

  // Pipe datapath: qualified by the sN_valid bits, so it needs no reset.
  always_ff @(posedge sysclk) begin
    s1_idx  <= cnt;
    s2_idx  <= s1_idx;
    s3_idx  <= s2_idx;
    s3_near <= near_c;
    s3_far  <= far_c;
    for (int a = 0; a < 3; a++) begin
      s1_dlo[a] <= sx(tab_min[cnt][a*W +: W]) - sx(orig_r[a*W +: W]);
      s1_dhi[a] <= sx(tab_max[cnt][a*W +: W]) - sx(orig_r[a*W +: W]);
      s2_tlo[a] <= scale(s1_dlo[a], inv_r[a*W +: W]);
      s2_thi[a] <= scale(s1_dhi[a], inv_r[a*W +: W]);
    end
  end

  assign ray_ready    = (state == IDLE);
  assign result_valid = (state == DONE);
  assign result_hit   = best_valid;
  assign result_idx   = best_idx;
  assign result_t     = best_t;
  assign scan_state   = state;

endmodule

// File: tb/tb_ray_box_scan.sv
// Self-checking bench for ray_box_scan: directed slab cases plus randomized rays checked
// against a whole-table reference model; RAY_BOX_SCAN_ANY_HIT_EN selects the first-hit model.
module tb_ray_box_scan;
  localparam int W = 24, FRAC = 12, NB = 8, IDX_W = 3;
  localparam longint ONE = 4096;

  logic clk = 1'b0, rst = 1'b1;
  logic box_wr_en = 1'b0;
  logic [IDX_W-1:0] box_wr_idx = '0;
  logic [3*W-1:0] box_wr_min = '0, box_wr_max = '0;
  logic ray_valid = 1'b0, ray_ready;
  logic [3*W-1:0] ray_orig = '0, ray_inv_dir = '0;
  logic [W-1:0] ray_t_max = '0;
  logic result_valid, result_ready = 1'b0, result_hit;
  logic [IDX_W-1:0] result_idx;
  logic [W-1:0] result_t;
  logic [1:0] scan_state;

  ray_box_scan #(.W(W), .FRAC(FRAC), .NUM_BOXES(NB)) dut (
    .sysclk(clk), .rst(rst),
    .box_wr_en(box_wr_en), .box_wr_idx(box_wr_idx),
    .box_wr_min(box_wr_min), .box_wr_max(box_wr_max),
    .ray_valid(ray_valid), .ray_ready(ray_ready),
    .ray_orig(ray_orig), .ray_inv_dir(ray_inv_dir), .ray_t_max(ray_t_max),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_hit(result_hit), .result_idx(result_idx), .result_t(result_t),
    .scan_state(scan_state)
  );

  // ---------------- clock / reset / bookkeeping
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int total = 0, bad = 0;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model
  typedef struct {bit hit; int idx; longint t; int due;} exp_t;
  exp_t exp_q[$];
  logic [3*W-1:0] sh_min [NB];
  logic [3*W-1:0] sh_max [NB];

  function automatic logic [3*W-1:0] v3(input longint x, input longint y, input longint z);
    return {z[W-1:0], y[W-1:0], x[W-1:0]};
  endfunction

  function automatic logic [3*W-1:0] cube(input longint u);
    return v3(u * ONE, u * ONE, u * ONE);
  endfunction

  function automatic longint tval(input logic [W-1:0] c, input logic [W-1:0] o,
                                  input logic [W-1:0] inv);
    longint d, p, hi_lim, lo_lim;
    hi_lim = (longint'(1) <<< (W - 1)) - 1;
    lo_lim = -(longint'(1) <<< (W - 1));
    d = longint'($signed(c)) - longint'($signed(o));
    p = (d * longint'($signed(inv))) >>> FRAC;
    if (p > hi_lim) p = hi_lim;
    if (p < lo_lim) p = lo_lim;
    return p;
  endfunction

  // Slab test against every box; due holds the latency in edges after acceptance.
  task automatic model(input logic [3*W-1:0] o, input logic [3*W-1:0] inv,
                       input logic [W-1:0] tm, output exp_t e);
    longint lo [3];
    longint hi [3];
    longint t0, t1, near, far, tc;
    bit h;
    e.hit = 0; e.idx = 0; e.t = 0; e.due = NB + 3;
    for (int b = 0; b < NB; b++) begin
      for (int a = 0; a < 3; a++) begin
        t0 = tval(sh_min[b][a*W +: W], o[a*W +: W], inv[a*W +: W]);
        t1 = tval(sh_max[b][a*W +: W], o[a*W +: W], inv[a*W +: W]);
        lo[a] = (t0 < t1) ? t0 : t1;
        hi[a] = (t0 < t1) ? t1 : t0;
      end
      near = lo[0]; far = hi[0];
      foreach (lo[a]) begin
        if (lo[a] > near) near = lo[a];
        if (hi[a] < far) far = hi[a];
      end
      h  = (near <= far) && (far >= 0) && (near <= longint'($signed(tm)));
      tc = (near < 0) ? 0 : near;
      if (h && (!e.hit || tc < e.t)) begin
        e.hit = 1; e.idx = b; e.t = tc;
      end
`ifdef RAY_BOX_SCAN_ANY_HIT_EN
      if (h) begin
        e.due = b + 4;
        break;
      end
`endif
    end
  endtask

  task automatic pin(input string tag, input exp_t e, input bit h, input int idx,
                     input longint t, input int due);
    chk({tag, "_model_hit"}, e.hit, h);
    chk({tag, "_model_idx"}, e.idx, idx);
    chk({tag, "_model_t"}, e.t, t);
    chk({tag, "_model_lat"}, e.due, due);
  endtask

  // ---------------- compare process
  bit prev_v = 0;
  always @(negedge clk) begin
    if (rst) prev_v = 0;
    else begin
      if (result_valid) begin
        if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          if (!prev_v) chk("result_latency", cyc, exp_q[0].due);
          chk("result_hit", longint'(result_hit), exp_q[0].hit);
          chk("result_idx", longint'(result_idx), exp_q[0].idx);
          chk("result_t", longint'($signed(result_t)), exp_q[0].t);
          chk("ray_ready_busy", longint'(ray_ready), 0);
          if (result_ready) void'(exp_q.pop_front());
        end
      end
      prev_v = result_valid;
    end
  end

  // ---------------- driver tasks
  task automatic write_box(input int i, input logic [3*W-1:0] mn, input logic [3*W-1:0] mx);
    box_wr_en = 1; box_wr_idx = IDX_W'(i); box_wr_min = mn; box_wr_max = mx;
    if (ray_ready) begin
      sh_min[i] = mn; sh_max[i] = mx;
    end
    tick();
    box_wr_en = 0;
  endtask

  task automatic fill(input logic [3*W-1:0] mn, input logic [3*W-1:0] mx);
    for (int i = 0; i < NB; i++) write_box(i, mn, mx);
  endtask

  task automatic wait_idle();
    int budget = 0;
    while (!ray_ready && budget < 200) begin
      tick();
      budget++;
    end
    if (!ray_ready) chk("ray_ready_timeout", 0, 1);
  endtask

  task automatic run_ray(input logic [3*W-1:0] o, input logic [3*W-1:0] inv,
                         input logic [W-1:0] tm, input bit wr, input int wi,
                         input logic [3*W-1:0] wmn, input logic [3*W-1:0] wmx);
    exp_t e;
    wait_idle();
    ray_valid = 1; ray_orig = o; ray_inv_dir = inv; ray_t_max = tm;
    if (wr) begin
      box_wr_en = 1; box_wr_idx = IDX_W'(wi); box_wr_min = wmn; box_wr_max = wmx;
      sh_min[wi] = wmn; sh_max[wi] = wmx;
    end
    model(o, inv, tm, e);
    e.due = e.due + cyc + 1;
    exp_q.push_back(e);
    tick();
    ray_valid = 0; box_wr_en = 0;
  endtask

  // A ray offer and a box write while busy; the shadow table only takes writes while idle.
  task automatic poke();
    ray_valid = 1; ray_orig = v3(1, 2, 3); ray_inv_dir = cube(1); ray_t_max = W'(100 * ONE);
    write_box(0, cube(-1), cube(1));
    ray_valid = 0;
  endtask

  task automatic wait_result(input int hold);
    int budget = 0;
    while (!result_valid && budget < 100) begin
      tick();
      budget++;
    end
    if (!result_valid) begin
      chk("result_timeout", 0, 1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    repeat (hold) tick();
    result_ready = 1;
    tick();
    result_ready = 0;
  endtask

  function automatic longint rnd(input longint lo, input longint hi);
    return lo + longint'($urandom_range(32'(hi - lo)));
  endfunction

  // ---------------- stimulus
  logic [3*W-1:0] far_mn, far_mx, neg5, unit;
  exp_t e;
  initial begin
    for (int i = 0; i < NB; i++) begin
      sh_min[i] = '0; sh_max[i] = '0;
    end
    far_mn = cube(1000); far_mx = cube(1001);
    neg5 = cube(-5); unit = cube(1);
    repeat (3) tick();
    rst = 0;
    chk("rst_ray_ready", longint'(ray_ready), 1);
    chk("rst_result_valid", longint'(result_valid), 0);
    chk("rst_result_hit", longint'(result_hit), 0);
    chk("rst_result_idx", longint'(result_idx), 0);
    chk("rst_result_t", longint'(result_t), 0);

    // nearest hit, plus ignored offer/write while scanning
    fill(far_mn, far_mx);
    write_box(0, cube(0), cube(10));
    write_box(3, cube(2), cube(4));
    model(neg5, unit, W'(100 * ONE), e);
    pin("nearest", e, 1, 0, 20480, 11);
    run_ray(neg5, unit, W'(100 * ONE), 0, 0, '0, '0);
    poke();
    wait_result(0);

    // tie keeps lower index; result held 5 cycles
    write_box(1, cube(0), cube(10));
    model(neg5, unit, W'(100 * ONE), e);
    pin("tie", e, 1, 0, 20480, 11);
    run_ray(neg5, unit, W'(100 * ONE), 0, 0, '0, '0);
    wait_result(5);

    // miss on all boxes
    fill('0, '0);
    write_box(0, v3(20 * ONE, 20 * ONE, -30 * ONE), v3(30 * ONE, 30 * ONE, -20 * ONE));
    model(v3(-5 * ONE, -4 * ONE, -5 * ONE), unit, W'(100 * ONE), e);
    pin("miss", e, 0, 0, 0, 11);
    run_ray(v3(-5 * ONE, -4 * ONE, -5 * ONE), unit, W'(100 * ONE), 0, 0, '0, '0);
    wait_result(1);

    // t_max rejects the hit at 5.0
    write_box(0, cube(0), cube(10));
    model(neg5, unit, W'(4 * ONE), e);
    pin("tmax", e, 0, 0, 0, 11);
    run_ray(neg5, unit, W'(4 * ONE), 0, 0, '0, '0);
    wait_result(0);

    // hits at boxes 2 and 5
    fill(far_mn, far_mx);
    write_box(2, cube(6), cube(8));
    write_box(5, cube(0), cube(10));
    model(neg5, unit, W'(100 * ONE), e);
`ifdef RAY_BOX_SCAN_ANY_HIT_EN
    pin("two_hits", e, 1, 2, 45056, 6);
`else
    pin("two_hits", e, 1, 5, 20480, 11);
`endif
    run_ray(neg5, unit, W'(100 * ONE), 0, 0, '0, '0);
    wait_result(2);

    // write on the accepting edge is seen by that ray
    fill(far_mn, far_mx);
    run_ray(neg5, unit, W'(100 * ONE), 1, 4, cube(0), cube(10));
    wait_result(0);

    // reset mid-scan abandons the ray and clears the table
    wait_idle();
    ray_valid = 1; ray_orig = neg5; ray_inv_dir = unit; ray_t_max = W'(100 * ONE);
    tick();
    ray_valid = 0;
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < NB; i++) begin
      sh_min[i] = '0; sh_max[i] = '0;
    end
    chk("mid_rst_ray_ready", longint'(ray_ready), 1);
    chk("mid_rst_result_valid", longint'(result_valid), 0);
    repeat (15) tick();
    chk("mid_rst_no_result", longint'(result_valid), 0);

    // randomized rays
    for (int n = 0; n < 40; n++) begin
      logic [3*W-1:0] o, inv, mn, mx;
      longint c [3];
      longint h [3];
      longint lim;
      for (int k = 0; k < int'($urandom_range(3)); k++) begin
        foreach (c[a]) begin
          c[a] = rnd(-16 * ONE, 16 * ONE);
          h[a] = rnd(0, 6 * ONE);
        end
        mn = v3(c[0] - h[0], c[1] - h[1], c[2] - h[2]);
        mx = v3(c[0] + h[0], c[1] + h[1], c[2] + h[2]);
        write_box(int'($urandom_range(NB - 1)), mn, mx);
      end
      lim = ($urandom_range(7) == 0) ? (longint'(1) <<< (W - 1)) - 1 : 3 * ONE;
      o   = v3(rnd(-8 * ONE, 8 * ONE), rnd(-8 * ONE, 8 * ONE), rnd(-8 * ONE, 8 * ONE));
      inv = v3(rnd(-lim, lim), rnd(-lim, lim), rnd(-lim, lim));
      foreach (c[a]) c[a] = rnd(-10 * ONE, 10 * ONE);
      run_ray(o, inv, W'(rnd(-ONE, 60 * ONE)), ($urandom_range(3) == 0),
              int'($urandom_range(NB - 1)), v3(c[0], c[1], c[2]),
              v3(c[0] + 4 * ONE, c[1] + 4 * ONE, c[2] + 4 * ONE));
      if ($urandom_range(3) == 0) poke();
      wait_result(int'($urandom_range(3)));
    end

    repeat (4) tick();
    chk("exp_queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
